// File: rtl/boe_stat_collector_pkg.sv
// Shared definitions for the BOE statistics path: word widths, frame size
// limit, collector state encoding and helpers shared with the sorter stage.
package boe_pkg;

  localparam int DW   = 8;   // sample width
  localparam int SW   = 11;  // sum word width (SW >= DW+3)
  localparam int NMAX = 6;   // maximum samples per frame

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_MIN  = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_DIVIDE   = 3'd3,
    ST_DONE     = 3'd4
  } boe_state_e;

  // Map the 3-bit sample count onto 1..NMAX (0 means one sample).
  function automatic logic [2:0] boe_clamp_n(input logic [2:0] dn);
    logic [2:0] n;
    if (dn == 3'd0) begin
      n = 3'd1;
    end else if (dn > 3'(NMAX)) begin
      n = 3'(NMAX);
    end else begin
      n = dn;
    end
    return n;
  endfunction

  // Average of two samples, carry kept in a DW+1-bit add.
  function automatic logic [DW-1:0] boe_avg2(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    return DW'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

endpackage

// File: rtl/boe_stat_collector_if.sv
// Result-stream and statistics bundle between the BOE sorter, the stat
// collector and whatever consumes the statistics.
interface boe_stat_collector_if;
  import boe_pkg::*;

  logic [2:0]    data_num;
  logic          res_valid;
  logic [SW-1:0] result;
  logic          busy;
  logic          stat_valid;
  logic [SW-1:0] sum_o;
  logic [DW-1:0] min_o;
  logic [DW-1:0] max_o;
  logic [DW-1:0] median_o;
  logic [DW-1:0] mean_o;
  logic          err;

  // Upstream side: drives the result stream, observes the statistics.
  modport master (
    output data_num, res_valid, result,
    input  busy, stat_valid, sum_o, min_o, max_o, median_o, mean_o, err
  );

  // Collector side.
  modport slave (
    input  data_num, res_valid, result,
    output busy, stat_valid, sum_o, min_o, max_o, median_o, mean_o, err
  );
endinterface

// File: rtl/boe_stat_collector_div.sv
// Bit-serial restoring divider: SW-bit dividend by 3-bit divisor, one
// quotient bit per cycle MSB first, done pulses SW cycles after start.
// Only the low DW quotient bits are kept; callers guarantee the quotient fits.
module boe_serial_div
  import boe_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [SW-1:0] i_dividend,
  input  logic [2:0]    i_divisor,
  output logic          o_done,
  output logic [DW-1:0] o_quot
);

  logic [SW-1:0] r_dvd;
  logic [3:0]    r_rem;
  logic [2:0]    r_div;
  logic [DW-1:0] r_quot;
  logic [3:0]    r_cnt;
  logic          r_active;
  logic          r_done;

  logic [4:0]    w_trial;
  logic          w_ge;
  logic [3:0]    w_rem_next;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    w_trial = {r_rem, r_dvd[SW-1]};
    w_ge    = (w_trial >= {2'b00, r_div});
    if (w_ge) begin
      w_rem_next = w_trial[3:0] - {1'b0, r_div};
    end else begin
      w_rem_next = w_trial[3:0];
    end
  end

  // Load on start, then shift one quotient bit per cycle until done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd    <= '0;
      r_rem    <= 4'd0;
      r_div    <= 3'd0;
      r_quot   <= '0;
      r_cnt    <= 4'd0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_dvd    <= i_dividend;
        r_rem    <= 4'd0;
        r_div    <= i_divisor;
        r_quot   <= '0;
        r_cnt    <= 4'd0;
        r_active <= 1'b1;
      end else if (r_active) begin
        r_dvd  <= {r_dvd[SW-2:0], 1'b0};
        r_rem  <= w_rem_next;
        r_quot <= {r_quot[DW-2:0], w_ge};
        if (r_cnt == 4'(SW-1)) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else begin
        r_active <= 1'b0;
      end
    end
  end

  assign o_done = r_done;
  assign o_quot = r_quot;

endmodule

// File: rtl/boe_stat_collector.sv
// BOE statistics collector: reassembles one sorted frame (sum word, min
// word, N samples) and reports sum/min/max/median/mean with a done strobe.
// Optional frame consistency checker enabled by macro BOE_STAT_CHECK_EN;
// without it err is constant 0.
module boe_stat_collector
  import boe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  boe_stat_collector_if.slave bus
);

  boe_state_e    r_state;
  logic [2:0]    r_n;
  logic [2:0]    r_k;
  logic [SW-1:0] r_sum;
  logic [DW-1:0] r_min;
  logic [DW-1:0] r_buf [NMAX];
  logic          r_busy;
  logic          r_stat_valid;
  logic [SW-1:0] r_sum_o;
  logic [DW-1:0] r_min_o;
  logic [DW-1:0] r_max_o;
  logic [DW-1:0] r_median_o;
  logic [DW-1:0] r_mean_o;
  logic          r_err;

  logic [DW-1:0] w_sample;
  logic          w_last;
  logic          w_div_start;
  logic          w_div_done;
  logic [DW-1:0] w_quot;
  logic [DW-1:0] w_max;
  logic [DW-1:0] w_median;
  logic          w_err_next;

  assign w_sample    = bus.result[DW-1:0];
  assign w_last      = (r_k == (r_n - 3'd1));
  // Division starts on the same edge that stores the final sample.
  assign w_div_start = (r_state == ST_GET_DATA) && bus.res_valid && w_last;

  boe_serial_div u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (r_sum),
    .i_divisor  (r_n),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  // Pick max and median out of the sorted buffer for the current N.
  always_comb begin
    w_max    = r_buf[0];
    w_median = r_buf[0];
    case (r_n)
      3'd1: begin w_max = r_buf[0]; w_median = r_buf[0]; end
      3'd2: begin w_max = r_buf[1]; w_median = boe_avg2(r_buf[0], r_buf[1]); end
      3'd3: begin w_max = r_buf[2]; w_median = r_buf[1]; end
      3'd4: begin w_max = r_buf[3]; w_median = boe_avg2(r_buf[1], r_buf[2]); end
      3'd5: begin w_max = r_buf[4]; w_median = r_buf[2]; end
      3'd6: begin w_max = r_buf[5]; w_median = boe_avg2(r_buf[2], r_buf[3]); end
      default: begin w_max = r_buf[0]; w_median = r_buf[0]; end
    endcase
  end

`ifdef BOE_STAT_CHECK_EN
  logic [SW-1:0] r_run_sum;
  logic          r_chk_flag;
  logic [DW-1:0] w_prev;

  // Predecessor of the sample being written (unused for the first one).
  always_comb begin
    if (r_k == 3'd0) begin
      w_prev = '0;
    end else begin
      w_prev = r_buf[r_k - 3'd1];
    end
  end

  // Running sample sum and sticky per-frame error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_sum  <= '0;
      r_chk_flag <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.res_valid) begin
            r_run_sum  <= '0;
            r_chk_flag <= 1'b0;
          end
        end
        ST_GET_DATA: begin
          if (bus.res_valid) begin
            r_run_sum <= r_run_sum + {{(SW-DW){1'b0}}, w_sample};
            if ((r_k == 3'd0) && (w_sample != r_min)) begin
              r_chk_flag <= 1'b1;
            end
            if ((r_k != 3'd0) && (w_sample < w_prev)) begin
              r_chk_flag <= 1'b1;
            end
          end
        end
        ST_DIVIDE, ST_DONE: begin
          if (bus.res_valid) begin
            r_chk_flag <= 1'b1;
          end
        end
        default: begin
          r_chk_flag <= r_chk_flag;
        end
      endcase
    end
  end

  assign w_err_next = r_chk_flag | (r_run_sum != r_sum);
`else
  assign w_err_next = 1'b0;
`endif

  // Frame FSM: collect words, wait for the divider, publish registered stats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_n          <= 3'd0;
      r_k          <= 3'd0;
      r_sum        <= '0;
      r_min        <= '0;
      for (int i = 0; i < NMAX; i++) begin
        r_buf[i] <= '0;
      end
      r_busy       <= 1'b0;
      r_stat_valid <= 1'b0;
      r_sum_o      <= '0;
      r_min_o      <= '0;
      r_max_o      <= '0;
      r_median_o   <= '0;
      r_mean_o     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_stat_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.res_valid) begin
            r_sum   <= bus.result;
            r_n     <= boe_clamp_n(bus.data_num);
            r_busy  <= 1'b1;
            r_state <= ST_GET_MIN;
          end
        end
        ST_GET_MIN: begin
          if (bus.res_valid) begin
            r_min   <= w_sample;
            r_k     <= 3'd0;
            r_state <= ST_GET_DATA;
          end
        end
        ST_GET_DATA: begin
          if (bus.res_valid) begin
            r_buf[r_k] <= w_sample;
            r_k        <= r_k + 3'd1;
            if (w_last) begin
              r_state <= ST_DIVIDE;
            end
          end
        end
        ST_DIVIDE: begin
          // Stray words here are dropped; the checker flags them.
          if (w_div_done) begin
            r_stat_valid <= 1'b1;
            r_sum_o      <= r_sum;
            r_min_o      <= r_min;
            r_max_o      <= w_max;
            r_median_o   <= w_median;
            r_mean_o     <= w_quot;
            r_err        <= w_err_next;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.stat_valid = r_stat_valid;
  assign bus.sum_o      = r_sum_o;
  assign bus.min_o      = r_min_o;
  assign bus.max_o      = r_max_o;
  assign bus.median_o   = r_median_o;
  assign bus.mean_o     = r_mean_o;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_boe_stat_collector.sv
// Scoreboard bench for boe_stat_collector: directed frames from the test
// plan plus randomized sorted frames, checked against a frame-level model.
module tb_boe_stat_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  boe_stat_collector_if bus_if();

  boe_stat_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int sum;
    int mn;
    int mx;
    int med;
    int mean;
    int err;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   smp[6];
  bit   prev_sv = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: pop one expectation per stat_valid pulse and compare.
  always @(negedge clk) begin
    if (rst) begin
      prev_sv = 1'b0;
    end else begin
      if (bus_if.stat_valid) begin
        checks++;
        if (prev_sv) begin
          errors++;
          $display("FAIL stat_valid_width: high for two consecutive cycles at cycle %0d", cyc);
        end
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_stat_valid: pulse at cycle %0d with no frame expected", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sum_o",    int'(bus_if.sum_o),    mon_e.sum);
          chk("min_o",    int'(bus_if.min_o),    mon_e.mn);
          chk("max_o",    int'(bus_if.max_o),    mon_e.mx);
          chk("median_o", int'(bus_if.median_o), mon_e.med);
          chk("mean_o",   int'(bus_if.mean_o),   mon_e.mean);
          chk("err",      int'(bus_if.err),      mon_e.err);
          chk("latency",  cyc,                   mon_e.cyc);
          chk("busy_at_valid", int'(bus_if.busy), 1);
        end
      end
      prev_sv = bus_if.stat_valid;
    end
  end

  // Called at a negedge; word is accepted at the next posedge.
  task automatic send_word(input int dn, input int val, input int gap);
    bus_if.data_num  = dn[2:0];
    bus_if.result    = val[10:0];
    bus_if.res_valid = 1'b1;
    @(negedge clk);
    bus_if.res_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Send one frame from smp[] and push the model's expected statistics.
  task automatic run_frame(input int dn, input int sumw, input int minw,
                           input int maxgap, input bit extra);
    int   n;
    int   s;
    int   med;
    bit   desc;
    exp_t e;
    n = (dn == 0) ? 1 : ((dn > 6) ? 6 : dn);
    s = 0;
    desc = 1'b0;
    for (int i = 0; i < n; i++) begin
      s += smp[i];
      if (i > 0 && smp[i] < smp[i-1]) desc = 1'b1;
    end
    if (n % 2 == 1) med = smp[(n-1)/2];
    else            med = (smp[n/2-1] + smp[n/2]) / 2;
    send_word(dn, sumw, int'($urandom_range(0, maxgap)));
    send_word(dn, minw, int'($urandom_range(0, maxgap)));
    for (int i = 0; i < n; i++) begin
      send_word(dn, smp[i], (i == n-1) ? 0 : int'($urandom_range(0, maxgap)));
    end
    e.sum  = sumw;
    e.mn   = minw;
    e.mx   = smp[n-1];
    e.med  = med;
    e.mean = (sumw / n) % 256;
`ifdef BOE_STAT_CHECK_EN
    e.err  = ((s != sumw) || (minw != smp[0]) || desc || extra) ? 1 : 0;
`else
    e.err  = 0;
`endif
    e.cyc  = cyc + 12;
    sb_q.push_back(e);
    if (extra) begin
      repeat (3) @(negedge clk);
      send_word(dn, 200, 0);
    end
    repeat (16) @(negedge clk);
  endtask

  task automatic set3(input int a, input int b, input int c);
    smp[0] = a; smp[1] = b; smp[2] = c;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s;
    int t;
    bus_if.data_num  = 3'd0;
    bus_if.res_valid = 1'b0;
    bus_if.result    = 11'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy",       int'(bus_if.busy),       0);
    chk("rst_stat_valid", int'(bus_if.stat_valid), 0);
    chk("rst_sum_o",      int'(bus_if.sum_o),      0);
    chk("rst_mean_o",     int'(bus_if.mean_o),     0);
    chk("rst_err",        int'(bus_if.err),        0);
    rst = 1'b0;
    @(negedge clk);

    // N=3 basic frame, back-to-back words.
    set3(2, 5, 9);
    run_frame(3, 16, 2, 0, 1'b0);
    // N=4 with gaps.
    smp[0] = 10; smp[1] = 20; smp[2] = 30; smp[3] = 41;
    run_frame(4, 101, 10, 3, 1'b0);
    // N=6 all 255.
    for (int i = 0; i < 6; i++) smp[i] = 255;
    run_frame(6, 1530, 255, 1, 1'b0);
    // data_num=0 -> N=1.
    smp[0] = 77;
    run_frame(0, 77, 77, 0, 1'b0);
    // data_num=7 -> N=6.
    smp[0] = 1; smp[1] = 2; smp[2] = 3; smp[3] = 100; smp[4] = 200; smp[5] = 250;
    run_frame(7, 556, 1, 2, 1'b0);

    // Reset in the middle of an N=5 frame.
    send_word(5, 50, 0);
    send_word(5, 1, 0);
    send_word(5, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_sum_o",  int'(bus_if.sum_o),  0);
    chk("midrst_max_o",  int'(bus_if.max_o),  0);
    chk("midrst_busy",   int'(bus_if.busy),   0);
    rst = 1'b0;
    @(negedge clk);
    smp[0] = 3; smp[1] = 4;
    run_frame(2, 7, 3, 0, 1'b0);

    // Consistency cases: bad sum, descending, stray word, then clean.
    set3(2, 5, 9);
    run_frame(3, 17, 2, 0, 1'b0);
    set3(2, 5, 3);
    run_frame(3, 10, 2, 1, 1'b0);
    set3(4, 6, 8);
    run_frame(3, 18, 4, 0, 1'b1);
    set3(2, 5, 9);
    run_frame(3, 16, 2, 0, 1'b0);

    // Randomized sorted frames.
    for (int f = 0; f < 20; f++) begin
      int dn;
      dn = int'($urandom_range(0, 7));
      n = (dn == 0) ? 1 : ((dn > 6) ? 6 : dn);
      for (int i = 0; i < 6; i++) smp[i] = int'($urandom_range(0, 255));
      for (int i = 0; i < n; i++) begin
        for (int j = 0; j < n - 1 - i; j++) begin
          if (smp[j] > smp[j+1]) begin
            t = smp[j]; smp[j] = smp[j+1]; smp[j+1] = t;
          end
        end
      end
      s = 0;
      for (int i = 0; i < n; i++) s += smp[i];
      run_frame(dn, s, smp[0], 3, 1'b0);
    end

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 40 && sb_q.size() != 0; w++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected frames never reported", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
